matvec_result_packer: RTL and testbench

Downstream stage of `matvec_multiplier`: captures its per-row Q20.12 results, optionally adds a per-row bias, and saturates each value to Q4.12. It buffers a full result vector and replays it as BANDWIDTH-wide chunk writes. The chunk write port matches the `vector_write_enable`/`vector_base_addr`/`vector_in` port of the next layer's `matvec_multiplier`.

---
 rtl/matvec_result_packer.sv | 161 ++++++++++++++++
 tb/tb_matvec_result_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_result_packer.sv
// rtl/matvec_result_packer.sv - collects Q20.12 row results, adds an optional bias, saturates to Q4.12 and replays them as chunks
// Optional feature macro: MATVEC_BIAS_EN (adds a per-row bias memory and its write port)
module matvec_result_packer #(
  parameter int MAX_ROWS   = 64,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  localparam int AW = $clog2(MAX_ROWS),
  localparam int NW = AW + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NW-1:0]                num_rows,
  input  logic signed [2*DATA_WIDTH-1:0] result_in,
  input  logic                         result_valid,
`ifdef MATVEC_BIAS_EN
  input  logic                         bias_write_enable,
  input  logic [AW-1:0]                bias_addr,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
`endif
  output logic                         out_write_enable,
  input  logic                         out_ready,
  output logic [AW-1:0]                out_base_addr,
  output logic signed [DATA_WIDTH-1:0] out_data [0:BANDWIDTH-1],
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag,
  output logic                         drop_err
);

  localparam int SW = 2*DATA_WIDTH + 1;
  localparam logic [NW-1:0] BW_N = NW'(BANDWIDTH);
  localparam logic [NW-1:0] MAX_N = NW'(MAX_ROWS);
  localparam logic signed [SW-1:0] MAX_POS = {{(DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_NEG = {{(DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [NW-1:0] n;          // rows in the current vector
  logic [NW-1:0] row;        // next row to be written
  logic [NW-1:0] base;       // first row of the chunk being offered
  logic [NW-1:0] n_clamp;
  logic [NW-1:0] row_inc;
  logic          last_row;
  logic          last_chunk;
  logic          take;

  logic signed [DATA_WIDTH-1:0] result_buf [0:MAX_ROWS-1];
  logic signed [SW-1:0]         bias_term;
  logic signed [SW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] sat_val;
  logic                         sat_now;
  logic [NW-1:0]                idx;

  assign n_clamp    = (num_rows > MAX_N) ? MAX_N : num_rows;
  assign row_inc    = row + NW'(1);
  assign take       = (state == COLLECT) && result_valid;
  assign last_row   = (row_inc == n);
  assign last_chunk = ((base + BW_N) >= n);

`ifdef MATVEC_BIAS_EN
  logic signed [DATA_WIDTH-1:0] bias_mem [0:MAX_ROWS-1];

  // Bias memory: writable at any time, cleared to zero by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_ROWS; i++) bias_mem[i] <= '0;
    end else if (bias_write_enable) begin
      bias_mem[bias_addr] <= bias_in;
    end
  end
`endif

  // Widen, bias and saturate the incoming row result to Q4.12
  always_comb begin
    bias_term = '0;
`ifdef MATVEC_BIAS_EN
    bias_term = {{(DATA_WIDTH+1){bias_mem[row[AW-1:0]][DATA_WIDTH-1]}}, bias_mem[row[AW-1:0]]};
`endif
    sum     = {result_in[2*DATA_WIDTH-1], result_in} + bias_term;
    sat_now = 1'b0;
    sat_val = sum[DATA_WIDTH-1:0];
    if (sum > MAX_POS) begin
      sat_now = 1'b1;
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sum < MIN_NEG) begin
      sat_now = 1'b1;
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status outputs
  always_comb begin
    state_next       = state;
    out_write_enable = 1'b0;
    busy             = (state != IDLE);
    done             = 1'b0;
    case (state)
      IDLE:    if (start) state_next = (n_clamp == '0) ? DONE : COLLECT;
      COLLECT: if (result_valid && last_row) state_next = DRAIN;
      DRAIN: begin
        out_write_enable = 1'b1;
        if (out_ready && last_chunk) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters and sticky flags; a drop in the start cycle still sets drop_err
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n        <= '0;
      row      <= '0;
      base     <= '0;
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        n        <= n_clamp;
        row      <= '0;
        sat_flag <= 1'b0;
        drop_err <= 1'b0;
      end
      if (result_valid && state != COLLECT) drop_err <= 1'b1;
      if (take) begin
        row <= row_inc;
        if (sat_now)  sat_flag <= 1'b1;
        if (last_row) base <= '0;
      end
      if (state == DRAIN && out_ready) base <= base + BW_N;
    end
  end

  // Result buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (take) result_buf[row[AW-1:0]] <= sat_val;
  end

  // Chunk lanes, zero outside DRAIN and past the end of the vector
  always_comb begin
    idx           = '0;
    out_base_addr = (state == DRAIN) ? base[AW-1:0] : '0;
    for (int i = 0; i < BANDWIDTH; i++) begin
      idx         = base + NW'(i);
      out_data[i] = ((state == DRAIN) && (idx < n)) ? result_buf[idx[AW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_matvec_result_packer.sv
// tb/tb_matvec_result_packer.sv - directed self-checking bench for matvec_result_packer (BANDWIDTH 4 and 16 instances)
module tb_matvec_result_packer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [6:0] num_rows;
  logic signed [31:0] result_in;
  logic result_valid;
  logic out_ready;
`ifdef MATVEC_BIAS_EN
  logic bias_write_enable;
  logic [5:0] bias_addr;
  logic signed [15:0] bias_in;
`endif

  logic wen4, busy4, done4, sat4, drop4;
  logic [5:0] base4;
  logic signed [15:0] data4 [0:3];
  logic wen16, busy16, done16, sat16, drop16;
  logic [5:0] base16;
  logic signed [15:0] data16 [0:15];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matvec_result_packer #(.MAX_ROWS(64), .BANDWIDTH(4), .DATA_WIDTH(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .result_in(result_in), .result_valid(result_valid),
`ifdef MATVEC_BIAS_EN
    .bias_write_enable(bias_write_enable), .bias_addr(bias_addr), .bias_in(bias_in),
`endif
    .out_write_enable(wen4), .out_ready(out_ready), .out_base_addr(base4),
    .out_data(data4), .busy(busy4), .done(done4), .sat_flag(sat4), .drop_err(drop4)
  );

  matvec_result_packer #(.MAX_ROWS(64), .BANDWIDTH(16), .DATA_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .result_in(result_in), .result_valid(result_valid),
`ifdef MATVEC_BIAS_EN
    .bias_write_enable(bias_write_enable), .bias_addr(bias_addr), .bias_in(bias_in),
`endif
    .out_write_enable(wen16), .out_ready(out_ready), .out_base_addr(base16),
    .out_data(data16), .busy(busy16), .done(done16), .sat_flag(sat16), .drop_err(drop16)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input int val);
    result_in    = val;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask

  task automatic do_start(input int rows);
    start    = 1'b1;
    num_rows = 7'(rows);
    step();
    start    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp4 [0:3];
    rst_n = 1'b0; start = 1'b0; num_rows = '0; result_in = '0;
    result_valid = 1'b0; out_ready = 1'b1;
`ifdef MATVEC_BIAS_EN
    bias_write_enable = 1'b0; bias_addr = '0; bias_in = '0;
`endif
    step(); step();

    // Reset values
    check("rst_wen", int'(wen4), 0);
    check("rst_busy", int'(busy4), 0);
    check("rst_done", int'(done4), 0);
    check("rst_sat", int'(sat4), 0);
    check("rst_drop", int'(drop4), 0);
    check("rst_base", int'(base4), 0);
    check("rst_lane0", int'(data4[0]), 0);
    rst_n = 1'b1;
    step();

    // N=4, one chunk with saturation
    do_start(4);
    check("t1_busy", int'(busy4), 1);
    send(40960); send(0); send(40960); send(0);
    exp4 = '{32767, 0, 32767, 0};
    check("t1_wen", int'(wen4), 1);
    check("t1_base", int'(base4), 0);
    for (int i = 0; i < 4; i++) check($sformatf("t1_lane%0d", i), int'(data4[i]), exp4[i]);
    check("t1_sat", int'(sat4), 1);
    check("t1_d16_lane0", int'(data16[0]), 32767);
    check("t1_d16_lane4", int'(data16[4]), 0);
    step();
    check("t1_done", int'(done4), 1);
    check("t1_wen_off", int'(wen4), 0);
    step();
    check("t1_done_off", int'(done4), 0);
    check("t1_idle", int'(busy4), 0);

    // N=64 on the 16-lane instance: four back-to-back chunks
    do_start(64);
    for (int r = 0; r < 64; r++) send(4096);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("t2_wen_c%0d", c), int'(wen16), 1);
      check($sformatf("t2_base_c%0d", c), int'(base16), c * 16);
      for (int i = 0; i < 16; i++)
        check($sformatf("t2_c%0d_lane%0d", c, i), int'(data16[i]), 4096);
      step();
    end
    check("t2_done", int'(done16), 1);
    check("t2_sat", int'(sat16), 0);
    for (int i = 0; i < 40 && busy4; i++) step();
    check("t2_dut4_idle", int'(busy4), 0);
    step();

    // N=6 with backpressure on the second chunk
    do_start(6);
    send(-40000); send(-4096); send(1); send(2); send(3); send(4);
    exp4 = '{-32768, -4096, 1, 2};
    check("t3_base0", int'(base4), 0);
    for (int i = 0; i < 4; i++) check($sformatf("t3_c0_lane%0d", i), int'(data4[i]), exp4[i]);
    check("t3_sat", int'(sat4), 1);
    step();
    out_ready = 1'b0;
    exp4 = '{3, 4, 0, 0};
    for (int s = 0; s < 3; s++) begin
      check($sformatf("t3_hold%0d_wen", s), int'(wen4), 1);
      check($sformatf("t3_hold%0d_base", s), int'(base4), 4);
      for (int i = 0; i < 4; i++)
        check($sformatf("t3_hold%0d_lane%0d", s, i), int'(data4[i]), exp4[i]);
      check($sformatf("t3_hold%0d_done", s), int'(done4), 0);
      step();
    end
    out_ready = 1'b1;
    check("t3_still_wen", int'(wen4), 1);
    step();
    check("t3_done", int'(done4), 1);
    step();
    check("t3_idle", int'(busy4), 0);

    // Drops and an ignored second start
    send(5);
    check("t4_drop_idle", int'(drop4), 1);
    start = 1'b1; num_rows = 7'd2; result_in = 999; result_valid = 1'b1;
    step();
    start = 1'b0; result_valid = 1'b0;
    check("t4_busy", int'(busy4), 1);
    check("t4_drop_same", int'(drop4), 1);
    start = 1'b1; num_rows = 7'd5;
    send(100);
    start = 1'b0;
    send(200);
    exp4 = '{100, 200, 0, 0};
    check("t4_wen", int'(wen4), 1);
    for (int i = 0; i < 4; i++) check($sformatf("t4_lane%0d", i), int'(data4[i]), exp4[i]);
    step();
    check("t4_done", int'(done4), 1);
    step();
    check("t4_idle", int'(busy4), 0);

    // N=0: straight to done, no chunk
    do_start(0);
    check("t5_done", int'(done4), 1);
    check("t5_wen", int'(wen4), 0);
    step();
    check("t5_done_off", int'(done4), 0);
    check("t5_idle", int'(busy4), 0);
    check("t5_wen_off", int'(wen4), 0);

`ifdef MATVEC_BIAS_EN
    // Bias added before saturation
    bias_write_enable = 1'b1; bias_addr = 6'd0; bias_in = -16'sd8192;
    step();
    bias_write_enable = 1'b0;
    do_start(1);
    send(4096);
    check("t6_bias_lane0", int'(data4[0]), -4096);
    check("t6_bias_lane1", int'(data4[1]), 0);
    step(); step();
`endif

    // Reset asserted while draining
    out_ready = 1'b0;
    do_start(6);
    for (int r = 0; r < 6; r++) send(40960);
    check("t7_wen", int'(wen4), 1);
    check("t7_lane0", int'(data4[0]), 32767);
    rst_n = 1'b0;
    step();
    check("t7_rst_wen", int'(wen4), 0);
    check("t7_rst_busy", int'(busy4), 0);
    check("t7_rst_base", int'(base4), 0);
    check("t7_rst_lane0", int'(data4[0]), 0);
    check("t7_rst_sat", int'(sat4), 0);
    check("t7_rst_done", int'(done4), 0);
    check("t7_rst16_wen", int'(wen16), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
